simon_key_rev: RTL and testbench

SIMON_KEY_REV -- requirements
Module: simon_key_rev

---
 rtl/simon_pkg.sv | 24 ++
 rtl/simon_rot_mix.sv | 9 +
 rtl/simon_key_rev.sv | 133 +++++++++++++
 tb/tb_simon_key_rev.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - Simon 128/128 key schedule constants and FSM state type
package simon_pkg;

    localparam logic [63:0] SIMON_C      = 64'hFFFFFFFFFFFFFFFC;
    localparam logic [61:0] SIMON_Z2     = 62'h3369F885192C0EF5;
    localparam int          SIMON_NUM_RK = 68;
    localparam int          SIMON_Z_LEN  = 62;

    // Highest z index before wrapping back to 0.
    localparam logic [5:0] SIMON_Z_MAX       = 6'(SIMON_Z_LEN - 1);
    // z index used to derive k[65] from (k67, k66): (67 - 2) mod 62.
    localparam logic [5:0] SIMON_Z_EMIT      = 6'((SIMON_NUM_RK - 3) % SIMON_Z_LEN);
    // Index of the first round key emitted.
    localparam logic [6:0] SIMON_RK_TOP      = 7'(SIMON_NUM_RK - 1);
    // Step counter value on the last of the 66 forward expansion steps.
    localparam logic [6:0] SIMON_EXPAND_LAST = 7'(SIMON_NUM_RK - 3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } simon_state_t;

endpackage

// File: rtl/simon_rot_mix.sv
// rtl/simon_rot_mix.sv - combinational ROR3(x) ^ ROR4(x) term of the Simon key schedule
module simon_rot_mix (
    input  logic [63:0] x_i,
    output logic [63:0] y_o
);

    assign y_o = {x_i[2:0], x_i[63:3]} ^ {x_i[3:0], x_i[63:4]};

endmodule

// File: rtl/simon_key_rev.sv
// rtl/simon_key_rev.sv - Simon 128/128 reverse key schedule (k67 down to k0); optional SIMON_KEY_REV_DIRECT_EN adds load_direct
module simon_key_rev
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_hi,
    input  logic [63:0] key_lo,
`ifdef SIMON_KEY_REV_DIRECT_EN
    input  logic        load_direct,
`endif
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [63:0] rk,
    output logic [6:0]  rk_idx,
    output logic        rk_last
);

    simon_state_t state_q, state_d;
    // a holds the newer key word, b the older one: (k[i-1], k[i-2]) while
    // expanding, (k[i], k[i-1]) while emitting.
    logic [63:0]  a_q, a_d;
    logic [63:0]  b_q, b_d;
    logic [5:0]   z_q, z_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [6:0]   idx_q, idx_d;

    logic         direct_sel;
    logic [63:0]  mix_in;
    logic [63:0]  mix_out;
    logic [63:0]  round_c;
    logic [63:0]  fwd_key;
    logic [63:0]  rev_key;

`ifdef SIMON_KEY_REV_DIRECT_EN
    assign direct_sel = load_direct;
`else
    assign direct_sel = 1'b0;
`endif

    // The rotate term always acts on k[i-1]: a while expanding, b while emitting,
    // so one mixer serves both directions.
    assign mix_in  = (state_q == ST_EMIT) ? b_q : a_q;
    assign round_c = SIMON_C ^ {63'd0, SIMON_Z2[z_q]};
    assign fwd_key = round_c ^ b_q ^ mix_out;
    assign rev_key = round_c ^ a_q ^ mix_out;

    simon_rot_mix u_rot_mix (
        .x_i (mix_in),
        .y_o (mix_out)
    );

    // Next-state and datapath update for the IDLE / EXPAND / EMIT sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d   = key_hi;
                    b_d   = key_lo;
                    cnt_d = 7'd0;
                    if (direct_sel) begin
                        z_d     = SIMON_Z_EMIT;
                        idx_d   = SIMON_RK_TOP;
                        state_d = ST_EMIT;
                    end else begin
                        z_d     = 6'd0;
                        state_d = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                a_d = fwd_key;
                b_d = a_q;
                if (cnt_q == SIMON_EXPAND_LAST) begin
                    // z is left on the index that produced k67, which is
                    // exactly the one needed to recover k65.
                    idx_d   = SIMON_RK_TOP;
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    z_d   = (z_q == SIMON_Z_MAX) ? 6'd0 : z_q + 6'd1;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (idx_q == 7'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        a_d   = b_q;
                        b_d   = rev_key;
                        idx_d = idx_q - 7'd1;
                        z_d   = (z_q == 6'd0) ? SIMON_Z_MAX : z_q - 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            z_q     <= 6'd0;
            cnt_q   <= 7'd0;
            idx_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q == ST_EXPAND) || (state_q == ST_EMIT);
    assign rk_valid = (state_q == ST_EMIT);
    assign rk       = rk_valid ? a_q : 64'd0;
    assign rk_idx   = idx_q;
    assign rk_last  = rk_valid && (idx_q == 7'd0);

endmodule

// File: tb/tb_simon_key_rev.sv
// tb/tb_simon_key_rev.sv - self-checking bench for simon_key_rev against a forward-schedule model
module tb_simon_key_rev;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key_hi;
    logic [63:0] key_lo;
`ifdef SIMON_KEY_REV_DIRECT_EN
    logic        load_direct;
`endif
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [63:0] rk;
    logic [6:0]  rk_idx;
    logic        rk_last;

    always #5 clk = ~clk;

    simon_key_rev dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_hi     (key_hi),
        .key_lo     (key_lo),
`ifdef SIMON_KEY_REV_DIRECT_EN
        .load_direct(load_direct),
`endif
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk         (rk),
        .rk_idx     (rk_idx),
        .rk_last    (rk_last)
    );

    localparam logic [63:0] KEY_HI = 64'h0f0e0d0c0b0a0908;
    localparam logic [63:0] KEY_LO = 64'h0706050403020100;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_k [0:67];
    logic [63:0] got_k [$];
    int          got_idx [$];
    bit          got_last [$];
    int          lat;
    int          stall_err;
    bit          tmo;
    logic        end_busy;
    logic        end_valid;

    function automatic logic [63:0] ror(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    task automatic build_model(input logic [63:0] k1, input logic [63:0] k0);
        logic [61:0] z2;
        z2 = 62'h3369F885192C0EF5;
        exp_k[0] = k0;
        exp_k[1] = k1;
        for (int i = 2; i < 68; i++)
            exp_k[i] = 64'hFFFFFFFFFFFFFFFC ^ {63'd0, z2[(i - 2) % 62]} ^ exp_k[i - 2]
                       ^ ror(exp_k[i - 1], 3) ^ ror(exp_k[i - 1], 4);
    endtask

    function automatic int seq_errors();
        int errs = 0;
        if (got_k.size() != 68) errs++;
        for (int n = 0; n < got_k.size() && n < 68; n++)
            if (got_k[n] !== exp_k[67 - n] || got_idx[n] != 67 - n || got_last[n] != (n == 67))
                errs++;
        return errs;
    endfunction

    task automatic run_schedule(input logic [63:0] khi, input logic [63:0] klo,
                                input bit direct, input bit rand_rdy, input bit poke);
        int  cyc;
        bit  done;
        bit  hold;
        logic [63:0] hk;
        logic [6:0]  hi;
        logic        hl;
        got_k.delete(); got_idx.delete(); got_last.delete();
        lat = -1; stall_err = 0; tmo = 0; done = 0;
        key_hi = khi; key_lo = klo; start = 1'b1; rk_ready = 1'b1;
`ifdef SIMON_KEY_REV_DIRECT_EN
        load_direct = direct;
`endif
        @(posedge clk); #1;
        start = 1'b0;
`ifdef SIMON_KEY_REV_DIRECT_EN
        load_direct = 1'b0;
`endif
        cyc = 1;
        while (!done && cyc < 3000) begin
            if (rk_valid && lat < 0) lat = cyc;
            key_hi   = {$urandom, $urandom};
            key_lo   = {$urandom, $urandom};
            rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = (poke && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            hold = rk_valid && !rk_ready;
            hk = rk; hi = rk_idx; hl = rk_last;
            if (rk_valid && rk_ready) begin
                got_k.push_back(rk);
                got_idx.push_back(int'(rk_idx));
                got_last.push_back(rk_last);
                if (rk_last) done = 1;
            end
            @(posedge clk); #1;
            cyc++;
            if (hold && (!rk_valid || rk !== hk || rk_idx !== hi || rk_last !== hl)) stall_err++;
        end
        start = 1'b0; rk_ready = 1'b1;
        tmo = !done;
        end_busy = busy;
        end_valid = rk_valid;
        if (direct) begin end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; rk_ready = 1'b1;
        key_hi = {$urandom, $urandom}; key_lo = {$urandom, $urandom};
`ifdef SIMON_KEY_REV_DIRECT_EN
        load_direct = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rk_valid); end
        n_checks++; if (rk !== 64'd0) begin n_fail++; $display("FAIL reset_rk got %h want 0", rk); end
        n_checks++; if (rk_idx !== 7'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", rk_idx); end
        n_checks++; if (rk_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", rk_last); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
    endtask

    task automatic test_known_vector();
        int e;
        build_model(KEY_HI, KEY_LO);
        run_schedule(KEY_HI, KEY_LO, 1'b0, 1'b0, 1'b0);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL known_timeout got %0d keys want 68", got_k.size()); end
        n_checks++; if (lat != 67) begin n_fail++; $display("FAIL known_latency got %0d want 67", lat); end
        n_checks++; if (got_k.size() != 68) begin n_fail++; $display("FAIL known_count got %0d want 68", got_k.size()); end
        e = seq_errors();
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL known_sequence got %0d bad keys want 0", e); end
        if (got_k.size() == 68) begin
            n_checks++; if (got_k[67] !== 64'h0706050403020100) begin n_fail++; $display("FAIL known_k0 got %h want 0706050403020100", got_k[67]); end
            n_checks++; if (got_k[66] !== 64'h0f0e0d0c0b0a0908) begin n_fail++; $display("FAIL known_k1 got %h want 0f0e0d0c0b0a0908", got_k[66]); end
            n_checks++; if (got_k[0] !== exp_k[67]) begin n_fail++; $display("FAIL known_k67 got %h want %h", got_k[0], exp_k[67]); end
        end
        n_checks++; if (end_busy !== 1'b0 || end_valid !== 1'b0) begin n_fail++; $display("FAIL known_idle_after got busy=%b valid=%b want 0 0", end_busy, end_valid); end
    endtask

    task automatic test_stall();
        int e;
        build_model(KEY_HI, KEY_LO);
        run_schedule(KEY_HI, KEY_LO, 1'b0, 1'b1, 1'b0);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL stall_timeout got %0d keys want 68", got_k.size()); end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", stall_err); end
        e = seq_errors();
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL stall_sequence got %0d bad keys want 0", e); end
    endtask

    task automatic test_start_ignored();
        int e;
        build_model(KEY_HI, KEY_LO);
        run_schedule(KEY_HI, KEY_LO, 1'b0, 1'b0, 1'b1);
        n_checks++; if (lat != 67) begin n_fail++; $display("FAIL poke_latency got %0d want 67", lat); end
        e = seq_errors();
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL poke_sequence got %0d bad keys want 0", e); end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [63:0] khi, klo;
        for (int r = 0; r < 3; r++) begin
            khi = {$urandom, $urandom};
            klo = {$urandom, $urandom};
            build_model(khi, klo);
            run_schedule(khi, klo, 1'b0, 1'b1, r == 2);
            e = seq_errors();
            n_checks++; if (e != 0 || tmo) begin n_fail++; $display("FAIL random_key_%0d got %0d bad keys timeout=%0b want 0 0", r, e, tmo); end
            n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL random_stall_%0d got %0d changes want 0", r, stall_err); end
        end
    endtask

    task automatic test_reset_mid();
        int  e;
        bit  hit = 0;
        build_model(KEY_HI, KEY_LO);
        key_hi = KEY_HI; key_lo = KEY_LO; start = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (rk_valid && rk_idx == 7'd30) hit = 1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL midreset_reach got idx %0d want 30", rk_idx); end
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got busy=%b valid=%b want 0 0", busy, rk_valid); end
        n_checks++; if (rk !== 64'd0 || rk_idx !== 7'd0 || rk_last !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got rk=%h idx=%0d last=%b want 0 0 0", rk, rk_idx, rk_last); end
        run_schedule(KEY_HI, KEY_LO, 1'b0, 1'b0, 1'b0);
        e = seq_errors();
        n_checks++; if (e != 0 || lat != 67) begin n_fail++; $display("FAIL midreset_rerun got %0d bad keys latency %0d want 0 67", e, lat); end
    endtask

`ifdef SIMON_KEY_REV_DIRECT_EN
    task automatic test_direct();
        int e;
        build_model(KEY_HI, KEY_LO);
        run_schedule(exp_k[67], exp_k[66], 1'b1, 1'b0, 1'b0);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL direct_latency got %0d want 1", lat); end
        e = seq_errors();
        n_checks++; if (e != 0) begin n_fail++; $display("FAIL direct_sequence got %0d bad keys want 0", e); end
        if (got_k.size() == 68) begin
            n_checks++; if (got_k[67] !== 64'h0706050403020100) begin n_fail++; $display("FAIL direct_k0 got %h want 0706050403020100", got_k[67]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef SIMON_KEY_REV_DIRECT_EN
        test_direct();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
